// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID->EX pipeline register sitting directly in front of the ALU. Captures one
//   decoded instruction per accepted handshake and presents its resolved
//   operands (a, b) and ALU operation downstream.
//   - Operand values are resolved against in-flight writers: EX/MEM result
//     first, then WB write data, then the register-file read value.
//   - A load in EX/MEM whose destination is read by the incoming instruction
//     cannot be forwarded yet, so the incoming instruction is held back one
//     cycle (a bubble is issued) and the bubble is counted.
//   - flush kills the registered instruction and refuses any incoming one.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   decode-side handshake
//   in_op, in_rs, in_rt   ALU operation and source register addresses
//   in_rs_val, in_rt_val  register-file read values for rs / rt
//   in_imm, in_use_imm    immediate and "operand b is the immediate" select
//   in_rd, in_rd_we       destination register and its write enable
//   in_is_load            instruction is a load
//   exm_we/rd/is_load/data  EX/MEM writer (forwarding and load-use source)
//   wb_we/rd/data         WB writer (forwarding source)
//   flush                 kill registered and incoming instruction
//   out_valid / out_ready ALU-side handshake
//   out_a, out_b, out_op  ALU operands and operation
//   out_rd, out_rd_we, out_is_load  fields carried forward
//   stall_cnt             saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 6,
  parameter int RAW  = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [RAW-1:0]  in_rs,
  input  logic [RAW-1:0]  in_rt,
  input  logic [XLEN-1:0] in_rs_val,
  input  logic [XLEN-1:0] in_rt_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [RAW-1:0]  in_rd,
  input  logic            in_rd_we,
  input  logic            in_is_load,
  input  logic            exm_we,
  input  logic [RAW-1:0]  exm_rd,
  input  logic            exm_is_load,
  input  logic [XLEN-1:0] exm_data,
  input  logic            wb_we,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [OPW-1:0]  out_op,
  output logic [RAW-1:0]  out_rd,
  output logic            out_rd_we,
  output logic            out_is_load,
  output logic [CNTW-1:0] stall_cnt
);

  // Resolve one source operand. Register 0 is hardwired zero, so it never
  // takes a forwarded value. A load in EX/MEM has no data yet and is not a
  // forwarding source (that case is handled as a load-use stall instead).
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic [RAW-1:0]  src,
    input logic [XLEN-1:0] rf_val,
    input logic            ex_we,
    input logic            ex_ld,
    input logic [RAW-1:0]  ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            w_we,
    input logic [RAW-1:0]  w_rd,
    input logic [XLEN-1:0] w_data
  );
    logic [XLEN-1:0] val;
    val = rf_val;
    if (src != '0) begin
      if (ex_we && !ex_ld && (ex_rd == src)) begin
        val = ex_data;
      end else if (w_we && (w_rd == src)) begin
        val = w_data;
      end
    end
    return val;
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    logic [CNTW-1:0] r;
    if (&c) begin
      r = c;
    end else begin
      r = c + 1'b1;
    end
    return r;
  endfunction

  // Registered state
  logic            valid_q,   valid_d;
  logic [XLEN-1:0] a_q,       a_d;
  logic [XLEN-1:0] b_q,       b_d;
  logic [OPW-1:0]  op_q,      op_d;
  logic [RAW-1:0]  rd_q,      rd_d;
  logic            rd_we_q,   rd_we_d;
  logic            is_load_q, is_load_d;
  logic [CNTW-1:0] cnt_q,     cnt_d;

  // Hazard / handshake
  logic            uses_rt;
  logic            hazard;
  logic            slot_free;
  logic            accept;
  logic [XLEN-1:0] a_fwd;
  logic [XLEN-1:0] b_fwd;

  // rs is always read; rt only when operand b is not the immediate.
  assign uses_rt = !in_use_imm;

  assign hazard = in_valid && exm_we && exm_is_load && (exm_rd != '0) &&
                  ((exm_rd == in_rs) || (uses_rt && (exm_rd == in_rt)));

  // The output slot can take a new instruction this cycle if it is empty or
  // its current occupant is being consumed.
  assign slot_free = !valid_q || out_ready;
  assign in_ready  = !flush && !hazard && slot_free;
  assign accept    = in_valid && in_ready;

  assign a_fwd = fwd_operand(in_rs, in_rs_val, exm_we, exm_is_load, exm_rd,
                             exm_data, wb_we, wb_rd, wb_data);
  assign b_fwd = fwd_operand(in_rt, in_rt_val, exm_we, exm_is_load, exm_rd,
                             exm_data, wb_we, wb_rd, wb_data);

  // Next-state: flush > accept > consume > hold. Data fields only change on
  // accept, so they stay stable while the consumer back-pressures.
  always_comb begin
    valid_d   = valid_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    is_load_d = is_load_q;
    cnt_d     = cnt_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      a_d       = a_fwd;
      b_d       = in_use_imm ? in_imm : b_fwd;
      op_d      = in_op;
      rd_d      = in_rd;
      rd_we_d   = in_rd_we;
      is_load_d = in_is_load;
    end else if (out_ready && valid_q) begin
      valid_d = 1'b0;
    end

    // A bubble is only counted when the stall actually costs an issue slot,
    // i.e. the stage would otherwise have accepted the instruction.
    if (hazard && !flush && slot_free) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // ---- ID/EX register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      is_load_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      is_load_q <= is_load_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_a       = a_q;
  assign out_b       = b_q;
  assign out_op      = op_q;
  assign out_rd      = rd_q;
  assign out_rd_we   = rd_we_q;
  assign out_is_load = is_load_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int OPW  = 6;
  localparam int RAW  = 5;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid, in_use_imm, in_rd_we, in_is_load;
  logic [OPW-1:0]  in_op;
  logic [RAW-1:0]  in_rs, in_rt, in_rd;
  logic [XLEN-1:0] in_rs_val, in_rt_val, in_imm;
  logic            exm_we, exm_is_load, wb_we, flush, out_ready;
  logic [RAW-1:0]  exm_rd, wb_rd;
  logic [XLEN-1:0] exm_data, wb_data;

  logic            in_ready, out_valid, out_rd_we, out_is_load;
  logic [XLEN-1:0] out_a, out_b;
  logic [OPW-1:0]  out_op;
  logic [RAW-1:0]  out_rd;
  logic [CNTW-1:0] stall_cnt;

  // Second instance with a narrow counter to reach saturation quickly.
  logic            s_in_ready, s_out_valid, s_out_rd_we, s_out_is_load;
  logic [XLEN-1:0] s_out_a, s_out_b;
  logic [OPW-1:0]  s_out_op;
  logic [RAW-1:0]  s_out_rd;
  logic [2:0]      s_stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic            m_valid, m_rd_we, m_is_load;
  logic [XLEN-1:0] m_a, m_b;
  logic [OPW-1:0]  m_op;
  logic [RAW-1:0]  m_rd;
  int              m_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .OPW(OPW), .RAW(RAW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rs_val(in_rs_val),
    .in_rt_val(in_rt_val), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_is_load(exm_is_load),
    .exm_data(exm_data), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.XLEN(XLEN), .OPW(OPW), .RAW(RAW), .CNTW(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rs_val(in_rs_val),
    .in_rt_val(in_rt_val), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_is_load(exm_is_load),
    .exm_data(exm_data), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_a(s_out_a), .out_b(s_out_b), .out_op(s_out_op), .out_rd(s_out_rd),
    .out_rd_we(s_out_rd_we), .out_is_load(s_out_is_load),
    .stall_cnt(s_stall_cnt)
  );

  task automatic drive_idle();
    in_valid = 0; in_op = '0; in_rs = '0; in_rt = '0; in_rs_val = '0;
    in_rt_val = '0; in_imm = '0; in_use_imm = 0; in_rd = '0; in_rd_we = 0;
    in_is_load = 0; exm_we = 0; exm_rd = '0; exm_is_load = 0; exm_data = '0;
    wb_we = 0; wb_rd = '0; wb_data = '0; flush = 0; out_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] m_src(input logic [RAW-1:0] s,
                                            input logic [XLEN-1:0] rf);
    if (s == 0) return rf;
    if (exm_we && !exm_is_load && exm_rd == s) return exm_data;
    if (wb_we && wb_rd == s) return wb_data;
    return rf;
  endfunction

  function automatic logic m_hazard();
    return in_valid && exm_we && exm_is_load && exm_rd != 0 &&
           (exm_rd == in_rs || (!in_use_imm && exm_rd == in_rt));
  endfunction

  function automatic logic m_ready();
    return !flush && !m_hazard() && (!m_valid || out_ready);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    #1;
    checks++;
    if ({out_valid, out_a, out_b, out_op, out_rd, out_rd_we, out_is_load} !== '0) begin
      errors++; $display("FAIL reset_init: out_valid=%0b out_a=%0h out_b=%0h, want all zero", out_valid, out_a, out_b);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_init_cnt: got %0d want 0", stall_cnt);
    end
    @(posedge clk); #1; rst_n = 1;
    // one load-use bubble, then one real instruction
    exm_we = 1; exm_is_load = 1; exm_rd = 5'd4; in_valid = 1; in_rs = 5'd4;
    tick();
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL reset_pre_cnt: got %0d want 1", stall_cnt);
    end
    exm_we = 0; in_op = 6'h2A; in_rs = 5'd1; in_rs_val = 32'hDEAD_BEEF;
    in_use_imm = 1; in_imm = 32'h55; in_rd = 5'd7; in_rd_we = 1; in_is_load = 1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_a !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL reset_pre_load: out_valid=%0b out_a=%0h want 1/deadbeef", out_valid, out_a);
    end
    in_valid = 0; out_ready = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({out_valid, out_a, out_b, out_op, out_rd, out_rd_we, out_is_load} !== '0) begin
      errors++; $display("FAIL reset_async: out_valid=%0b out_a=%0h out_op=%0h, want all zero", out_valid, out_a, out_op);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_async_cnt: got %0d want 0", stall_cnt);
    end
    tick();
    rst_n = 1;
  endtask

  task automatic test_forward();
    do_reset();
    in_valid = 1; in_rs = 5'd3; in_rs_val = 32'd1; in_use_imm = 1; in_imm = 32'h100;
    exm_we = 1; exm_rd = 5'd3; exm_data = 32'd7;
    wb_we = 1; wb_rd = 5'd3; wb_data = 32'd9;
    tick();
    checks++;
    if (out_a !== 32'd7 || out_valid !== 1'b1) begin
      errors++; $display("FAIL fwd_exm: out_a=%0d out_valid=%0b want 7/1", out_a, out_valid);
    end
    checks++;
    if (out_b !== 32'h100) begin
      errors++; $display("FAIL fwd_imm: out_b=%0h want 100", out_b);
    end
    exm_we = 0;
    tick();
    checks++;
    if (out_a !== 32'd9) begin
      errors++; $display("FAIL fwd_wb: out_a=%0d want 9", out_a);
    end
    wb_we = 0; in_use_imm = 0; in_rt = 5'd3; in_rt_val = 32'd2;
    exm_we = 1; exm_data = 32'd11;
    tick();
    checks++;
    if (out_a !== 32'd11 || out_b !== 32'd11) begin
      errors++; $display("FAIL fwd_rt: out_a=%0d out_b=%0d want 11/11", out_a, out_b);
    end
    exm_we = 0;
    tick();
    checks++;
    if (out_a !== 32'd1 || out_b !== 32'd2) begin
      errors++; $display("FAIL fwd_rf: out_a=%0d out_b=%0d want 1/2", out_a, out_b);
    end
  endtask

  task automatic test_r0();
    do_reset();
    in_valid = 1; in_rs = 5'd0; in_rs_val = 32'd0; in_use_imm = 1;
    exm_we = 1; exm_rd = 5'd0; exm_data = 32'd5; wb_we = 1; wb_rd = 5'd0; wb_data = 32'd6;
    tick();
    checks++;
    if (out_a !== 32'd0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL r0_fwd: out_a=%0d out_valid=%0b want 0/1", out_a, out_valid);
    end
    exm_is_load = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL r0_hazard: in_ready=%0b want 1", in_ready);
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL r0_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    exm_we = 1; exm_is_load = 1; exm_rd = 5'd4; exm_data = 32'hBAD;
    in_valid = 1; in_rs = 5'd1; in_rs_val = 32'h11; in_rt = 5'd4; in_rt_val = 32'h44;
    in_use_imm = 0; in_imm = 32'h77;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL lu_ready: in_ready=%0b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL lu_bubble: out_valid=%0b stall_cnt=%0d want 0/1", out_valid, stall_cnt);
    end
    in_use_imm = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL lu_imm_ready: in_ready=%0b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_b !== 32'h77 || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL lu_imm: out_valid=%0b out_b=%0h stall_cnt=%0d want 1/77/1", out_valid, out_b, stall_cnt);
    end
    // rs hazard while the occupant drains: bubble counted, slot empties
    in_rs = 5'd4;
    tick();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'd2) begin
      errors++; $display("FAIL lu_rs: out_valid=%0b stall_cnt=%0d want 0/2", out_valid, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1; in_op = 6'h05; in_rs = 5'd2; in_rs_val = 32'hAAAA; in_use_imm = 1;
    in_imm = 32'h1; in_rd = 5'd9; in_rd_we = 1;
    tick();
    out_ready = 0;
    in_op = 6'h06; in_rs_val = 32'hBBBB; in_imm = 32'h2; in_rd = 5'd10;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready[%0d]: in_ready=%0b want 0", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_a !== 32'hAAAA || out_b !== 32'h1 ||
          out_op !== 6'h05 || out_rd !== 5'd9) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%0b a=%0h b=%0h op=%0h rd=%0d want 1/aaaa/1/5/9",
                           i, out_valid, out_a, out_b, out_op, out_rd);
      end
    end
    // hazard while blocked by the consumer costs no extra bubble
    exm_we = 1; exm_is_load = 1; exm_rd = 5'd2;
    tick();
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL bp_cnt: stall_cnt=%0d want 0", stall_cnt);
    end
    exm_we = 0; exm_is_load = 0; out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: in_ready=%0b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_a !== 32'hBBBB || out_op !== 6'h06 || out_rd !== 5'd10) begin
      errors++; $display("FAIL bp_next: valid=%0b a=%0h op=%0h rd=%0d want 1/bbbb/6/10", out_valid, out_a, out_op, out_rd);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1; in_rs = 5'd1; in_rs_val = 32'h1234; in_use_imm = 1; in_imm = 32'h9;
    tick();
    flush = 1; in_rs_val = 32'h5678; in_imm = 32'h8;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: in_ready=%0b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_kill: out_valid=%0b want 0", out_valid);
    end
    // flush with a load-use hazard: no bubble counted
    exm_we = 1; exm_is_load = 1; exm_rd = 5'd1;
    tick();
    flush = 0; in_valid = 0; exm_we = 0; exm_is_load = 0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_a === 32'h5678 || out_b === 32'h8 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL flush_drop: valid=%0b a=%0h b=%0h cnt=%0d want 0/not 5678/not 8/0",
                         out_valid, out_a, out_b, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1; in_rs = 5'd6; exm_we = 1; exm_is_load = 1; exm_rd = 5'd6;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (s_stall_cnt !== 3'd7) begin
      errors++; $display("FAIL sat_cnt: got %0d want 7", s_stall_cnt);
    end
    checks++;
    if (stall_cnt !== 16'd10) begin
      errors++; $display("FAIL sat_wide: got %0d want 10", stall_cnt);
    end
  endtask

  task automatic test_random();
    logic            exp_ready, haz, acc;
    logic            n_valid;
    do_reset();
    m_valid = 0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0; m_rd_we = 0; m_is_load = 0;
    m_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      in_op       = 6'($urandom);
      in_rs       = 5'($urandom_range(0, 7));
      in_rt       = 5'($urandom_range(0, 7));
      in_rs_val   = $urandom;
      in_rt_val   = $urandom;
      in_imm      = $urandom;
      in_use_imm  = ($urandom_range(0, 2) == 0);
      in_rd       = 5'($urandom);
      in_rd_we    = 1'($urandom);
      in_is_load  = 1'($urandom);
      exm_we      = ($urandom_range(0, 3) != 0);
      exm_rd      = 5'($urandom_range(0, 7));
      exm_is_load = ($urandom_range(0, 9) < 3);
      exm_data    = $urandom;
      wb_we       = ($urandom_range(0, 3) != 0);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      flush       = ($urandom_range(0, 9) == 0);
      out_ready   = ($urandom_range(0, 9) < 6);
      #1;
      exp_ready = m_ready();
      haz       = m_hazard();
      checks++;
      if (in_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", cyc, in_ready, exp_ready);
      end
      acc = in_valid && exp_ready;
      if (haz && !flush && (!m_valid || out_ready) && m_cnt < 65535) m_cnt++;
      n_valid = m_valid;
      if (flush) n_valid = 0;
      else if (acc) begin
        n_valid = 1;
        m_a = m_src(in_rs, in_rs_val);
        m_b = in_use_imm ? in_imm : m_src(in_rt, in_rt_val);
        m_op = in_op; m_rd = in_rd; m_rd_we = in_rd_we; m_is_load = in_is_load;
      end else if (out_ready && m_valid) n_valid = 0;
      m_valid = n_valid;
      tick();
      checks++;
      if (out_valid !== m_valid || out_a !== m_a || out_b !== m_b || out_op !== m_op ||
          out_rd !== m_rd || out_rd_we !== m_rd_we || out_is_load !== m_is_load) begin
        errors++; $display("FAIL rnd_out[%0d]: valid=%0b a=%0h b=%0h op=%0h rd=%0d want %0b/%0h/%0h/%0h/%0d",
                           cyc, out_valid, out_a, out_b, out_op, out_rd, m_valid, m_a, m_b, m_op, m_rd);
      end
      checks++;
      if (stall_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", cyc, stall_cnt, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_r0();
    test_load_use();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
